seq_mult_ctl: RTL and testbench
===============================

// Module: seq_mult_ctl
// PURPOSE
//   Parametrised sequential shift-add multiplier with integrated control FSM.
//   Generalises the fixed 4x4 multiplier/FSM pair: any operand width, per-op
//   signed/unsigned mode, start/busy/done handshake, deterministic latency.
//   Sits between an operand source and a result consumer inside the arithmetic datapath.
// PARAMETERS
//   WIDTH     4   operand width in bits, legal 2..16
//   CNT_W     5   iteration counter width, must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk     in   1         rising-edge clock
//   reset   in   1         asynchronous, active-high reset
//   start   in   1         request; sampled only in IDLE
//   sgn     in   1         1 = two's-complement operands, 0 = unsigned; sampled with start
//   da      in   WIDTH     multiplicand; sampled with start
//   db      in   WIDTH     multiplier; sampled with start
//   busy    out  1         high while state != IDLE
//   done    out  1         one-cycle pulse; p is valid in the same cycle
//   p       out  2*WIDTH   product; held until the next done
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, counter=0, internal regs=0, p=0, done=0, busy=0.
// - States:
//     IDLE -> RUN   on start=1.
//     RUN  -> FIN   after WIDTH iterations.
//     FIN  -> IDLE  unconditionally.
// - Edge 0 (IDLE, start=1):
//     latch sgn;
//     magnitudes: |da|, |db| when sgn=1, else raw da, db;
//     neg flag = sgn & (da[MSB] ^ db[MSB]);
//     accumulator=0; counter=WIDTH.
// - Edges 1..WIDTH (RUN): one iteration each.
//     If multiplier LSB=1, add multiplicand into the accumulator upper half (WIDTH+1-bit add, carry kept).
//     Then shift {carry,acc} right 1; counter decrements.
//     Counter reaching 0 moves the FSM to FIN.
// - Edge WIDTH+1 (FIN):
//     p <= neg ? -acc : acc (2*WIDTH-bit two's complement); done <= 1; state -> IDLE.
// - done is high for exactly one cycle after edge WIDTH+1 and clears on the next edge.
// - Latency: WIDTH+1 cycles from start acceptance to done.
//   Throughput: one op per WIDTH+2 cycles; start is accepted in the done cycle.
// - start while busy=1: ignored.
//   No queuing; da, db, sgn are don't-care; the op in flight is undisturbed.
// - p is unchanged except at FIN and reset; done=0 does not clear p.
// - Signed edge case: da=db=-2**(WIDTH-1).
//   The magnitude is 2**(WIDTH-1), fits in WIDTH bits unsigned; the product +2**(2*WIDTH-2) fits.
//   No overflow is possible in either mode.
// - Zero operand: still takes the full WIDTH iterations; p=0.
//   Negation of 0 yields 0.
// - Reset mid-operation: aborts immediately.
//   No done is produced; p returns to 0.
// - busy is decoded combinationally from state; done and p are registered outputs.
// TESTING
//   T1 WIDTH=4, sgn=0, da=15, db=15, start 1 cycle -> done after 5 cycles, p=225 (0xE1).
//   T2 WIDTH=4, sgn=1, da=4'b1000(-8), db=7 -> p=8'hC8 (-56); da=db=4'b1000 -> p=8'h40 (+64).
//   T3 WIDTH=4, sgn=0, da=0, db=9 -> done still at 5 cycles, p=0.
//      Start held high throughout -> next op accepted in the done cycle.
//   T4 Accept da=3, db=5; pulse start again with da=15, db=15 on cycle 2 while busy
//      -> p=15, only one done.
//   T5 Assert reset 2 cycles into an op (prior p=225) -> p=0, busy=0, no done.
//      A new op after release completes normally.
//   T6 WIDTH=8, back-to-back, start held:
//        255*255 unsigned -> 65025;
//        then sgn=1 -128*-128 -> 16384;
//      dones exactly 10 cycles apart.

Source files
------------

// File: rtl/seq_mult_ctl.sv
// Sequential shift-add multiplier with an integrated start/busy/done control FSM.
// Signed operands are converted to magnitudes before the loop and the sign is
// reapplied to the product at the end. This keeps the iteration loop purely unsigned.
// Latency from start acceptance to done is WIDTH+1 cycles. A new start is
// accepted in the cycle where done is high.
module seq_mult_ctl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     da,
  input  logic [WIDTH-1:0]     db,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic                 neg;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;

  // Operand magnitudes; -(-2**(WIDTH-1)) wraps to 2**(WIDTH-1), which is exact as unsigned.
  always_comb begin
    mag_a = (sgn && da[WIDTH-1]) ? -da : da;
    mag_b = (sgn && db[WIDTH-1]) ? -db : db;
  end

  // One iteration: conditionally add the multiplicand into the upper half, carry kept.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  end

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Busy is decoded directly from the state.
  assign busy = (state != IDLE);

  // Datapath: operand capture, shift-add loop, sign fix-up and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      p      <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= sgn & (da[WIDTH-1] ^ db[WIDTH-1]);
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH);
          end
        end
        RUN: begin
          acc    <= {sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
        end
        FIN: begin
          p    <= neg ? -acc : acc;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_ctl.sv
// Directed self-checking bench for seq_mult_ctl.
// It drives a WIDTH=4 instance and a WIDTH=8 instance from one clock.
// Inputs are driven and outputs are sampled 1 ns after each rising edge.
module tb_seq_mult_ctl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH = 4 instance
  logic        reset4, start4, sgn4, busy4, done4;
  logic [3:0]  da4, db4;
  logic [7:0]  p4;

  // WIDTH = 8 instance
  logic        reset8, start8, sgn8, busy8, done8;
  logic [7:0]  da8, db8;
  logic [15:0] p8;

  seq_mult_ctl #(.WIDTH(4), .CNT_W(5)) u_dut4 (
    .clk(clk), .reset(reset4), .start(start4), .sgn(sgn4),
    .da(da4), .db(db4), .busy(busy4), .done(done4), .p(p4)
  );

  seq_mult_ctl #(.WIDTH(8), .CNT_W(5)) u_dut8 (
    .clk(clk), .reset(reset8), .start(start8), .sgn(sgn8),
    .da(da8), .db(db8), .busy(busy8), .done(done8), .p(p8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done4. n is the number of edges waited, and 99 means the wait timed out.
  task automatic wait_done4(output int n);
    n = 0;
    while (!done4 && n < 40) begin tick(); n++; end
    if (!done4) n = 99;
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (!done8 && n < 40) begin tick(); n++; end
    if (!done8) n = 99;
  endtask

  // Single op on the 4-bit DUT: start is pulsed for one cycle.
  task automatic run4(input string tag, input logic s, input logic [3:0] a,
                      input logic [3:0] b, input logic [7:0] exp_p);
    int n;
    sgn4 = s; da4 = a; db4 = b; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check({tag, "_busy"}, busy4, 1);
    wait_done4(n);
    check({tag, "_lat"}, n, 5);
    check({tag, "_p"}, p4, exp_p);
    tick();
    check({tag, "_done_clr"}, done4, 0);
    check({tag, "_p_hold"}, p4, exp_p);
  endtask

  initial begin
    int n, cnt_done;
    reset4 = 1'b1; reset8 = 1'b1;
    start4 = 0; sgn4 = 0; da4 = 0; db4 = 0;
    start8 = 0; sgn8 = 0; da8 = 0; db8 = 0;
    tick(); tick();
    reset4 = 1'b0; reset8 = 1'b0;
    tick();
    check("rst_p", p4, 0);
    check("rst_done", done4, 0);
    check("rst_busy", busy4, 0);

    // T1: unsigned maximum
    run4("t1_15x15", 1'b0, 4'd15, 4'd15, 8'hE1);
    // T2: signed cases, including the most-negative operand
    run4("t2_m8x7",  1'b1, 4'b1000, 4'd7, 8'hC8);
    run4("t2_m8xm8", 1'b1, 4'b1000, 4'b1000, 8'h40);
    run4("t2_3xm5",  1'b1, 4'd3, 4'b1011, 8'hF1);
    run4("t2_u8x7",  1'b0, 4'b1000, 4'd7, 8'd56);
    // T3: zero operand still takes the full latency
    run4("t3_0x9",   1'b0, 4'd0, 4'd9, 8'd0);

    // T3: start held high, so the next op is accepted in the done cycle
    sgn4 = 0; da4 = 4'd2; db4 = 4'd3; start4 = 1'b1;
    tick();
    wait_done4(n);
    check("t3h_lat1", n, 5);
    check("t3h_p1", p4, 6);
    da4 = 4'd5; db4 = 4'd6;
    tick();
    check("t3h_acc_busy", busy4, 1);
    start4 = 1'b0;
    wait_done4(n);
    check("t3h_gap", n + 1, 6);
    check("t3h_p2", p4, 30);
    tick();

    // T4: a start that arrives while busy is ignored
    sgn4 = 0; da4 = 4'd3; db4 = 4'd5; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    da4 = 4'd15; db4 = 4'd15; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    cnt_done = 0;
    for (int i = 0; i < 15; i++) begin
      if (done4) begin
        cnt_done++;
        check("t4_p", p4, 15);
      end
      tick();
    end
    check("t4_done_count", cnt_done, 1);
    check("t4_p_final", p4, 15);

    // T5: a reset in the middle of an op aborts it
    run4("t5_pre", 1'b0, 4'd15, 4'd15, 8'hE1);
    da4 = 4'd7; db4 = 4'd7; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    reset4 = 1'b1;
    #1;
    check("t5_rst_p", p4, 0);
    check("t5_rst_busy", busy4, 0);
    check("t5_rst_done", done4, 0);
    tick();
    reset4 = 1'b0;
    cnt_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done4 || busy4) cnt_done++;
      tick();
    end
    check("t5_no_done", cnt_done, 0);
    run4("t5_post", 1'b0, 4'd6, 4'd7, 8'd42);

    // T6: WIDTH=8, back-to-back ops with start held high
    sgn8 = 0; da8 = 8'd255; db8 = 8'd255; start8 = 1'b1;
    tick();
    wait_done8(n);
    check("t6_lat1", n, 9);
    check("t6_p1", p8, 65025);
    sgn8 = 1; da8 = 8'h80; db8 = 8'h80;
    tick();
    start8 = 1'b0;
    wait_done8(n);
    check("t6_gap", n + 1, 10);
    check("t6_p2", p8, 16384);
    tick();
    check("t6_done_clr", done8, 0);
    check("t6_idle", busy8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
